// File: rtl/hood_menu_ctrl_pkg.sv
// Shared definitions for the range-hood front panel: state encoding, key
// indices, default timing constants and the request priority order.
package hood_menu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STANDBY = 2'd1,
        ST_MENU    = 2'd2,
        ST_RUN     = 2'd3
    } hood_state_e;

    localparam int unsigned LONG_PRESS_CYCLES_DEF   = 32'd300_000_000;
    localparam int unsigned MENU_TIMEOUT_CYCLES_DEF = 32'd1_000_000_000;
    localparam int unsigned RUN_ACK_CYCLES_DEF      = 32'd8;

    localparam int unsigned KEY_POWER = 32'd0;
    localparam int unsigned KEY_MENU  = 32'd1;
    localparam int unsigned KEY_GEAR1 = 32'd2;
    localparam int unsigned KEY_GEAR2 = 32'd3;
    localparam int unsigned KEY_GEAR3 = 32'd4;
    localparam int unsigned KEY_CLEAN = 32'd5;
    localparam int unsigned KEY_NUM   = 32'd6;

    typedef struct packed {
        logic clean;
        logic first;
        logic second;
        logic third;
    } req_t;

    // At most one request per cycle: clean > gear1 > gear2 > gear3.
    function automatic req_t pick_req(input logic allow_clean, input logic [KEY_NUM-1:0] edges);
        req_t r;
        r = '0;
        if (allow_clean && edges[KEY_CLEAN]) begin
            r.clean = 1'b1;
        end else if (edges[KEY_GEAR1]) begin
            r.first = 1'b1;
        end else if (edges[KEY_GEAR2]) begin
            r.second = 1'b1;
        end else if (edges[KEY_GEAR3]) begin
            r.third = 1'b1;
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/hood_menu_ctrl_if.sv
// Panel-side bundle: debounced key levels and busy in, status and request
// pulses out. master = panel/environment, slave = controller.
interface hood_menu_ctrl_if;
    logic       power_key;
    logic       menu_key;
    logic       gear1_key;
    logic       gear2_key;
    logic       gear3_key;
    logic       clean_key;
    logic       busy;
    logic       power_on;
    logic       menu_active;
    logic       first_req;
    logic       second_req;
    logic       third_req;
    logic       clean_req;
    logic       abort;
    logic [1:0] state_dbg;

    modport master (
        output power_key, menu_key, gear1_key, gear2_key, gear3_key, clean_key, busy,
        input  power_on, menu_active, first_req, second_req, third_req, clean_req, abort, state_dbg
    );

    modport slave (
        input  power_key, menu_key, gear1_key, gear2_key, gear3_key, clean_key, busy,
        output power_on, menu_active, first_req, second_req, third_req, clean_req, abort, state_dbg
    );
endinterface

// File: rtl/hood_menu_ctrl_key_edge.sv
// Rising-edge detector for one key level. The history register resets high
// so a key already held when reset releases never produces an edge.
module key_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic edge_o
);
    logic prev_q;

    // Previous-level history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign edge_o = level_i & ~prev_q;
endmodule

// File: rtl/hood_menu_ctrl.sv
// Front-panel controller: turns key levels into power/menu state and gated
// single-cycle gear/clean requests for the downstream mode switcher.
module hood_menu_ctrl
    import hood_menu_ctrl_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES   = LONG_PRESS_CYCLES_DEF,
    parameter int unsigned MENU_TIMEOUT_CYCLES = MENU_TIMEOUT_CYCLES_DEF,
    parameter int unsigned RUN_ACK_CYCLES      = RUN_ACK_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    hood_menu_ctrl_if.slave  panel
);
    localparam int unsigned LP_W   = $clog2(LONG_PRESS_CYCLES + 32'd1);
    localparam int unsigned IDLE_W = $clog2(MENU_TIMEOUT_CYCLES + 32'd1);
    localparam int unsigned ACK_W  = $clog2(RUN_ACK_CYCLES + 32'd1);

    logic [KEY_NUM-1:0] level_s;
    logic [KEY_NUM-1:0] edge_s;
    hood_state_e        state_q, state_d;
    logic               armed_q, armed_d;
    logic [LP_W-1:0]    lp_q, lp_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [ACK_W-1:0]   ack_q, ack_d;
    logic               seen_q, seen_d;
    req_t               req_q, req_d;
    logic               abort_q, abort_d;
    logic               power_on_q, power_on_d;
    logic               menu_q, menu_d;
    logic               power_act_s;
    logic               pwr_edge_s;
    logic               long_press_s;
    logic               stay_menu_s;
    logic               stay_run_s;
    req_t               menu_req_s;
    req_t               run_req_s;

    assign level_s = {panel.clean_key, panel.gear3_key, panel.gear2_key,
                      panel.gear1_key, panel.menu_key, panel.power_key};

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_edge
        key_edge u_edge (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .level_i (level_s[k]),
            .edge_o  (edge_s[k])
        );
    end

    // The power key only acts while armed, i.e. after it was seen released.
    assign pwr_edge_s   = edge_s[KEY_POWER] & armed_q;
    assign long_press_s = level_s[KEY_POWER] & armed_q & (lp_q == LP_W'(LONG_PRESS_CYCLES - 32'd1));
    assign menu_req_s   = pick_req(1'b1, edge_s);
    assign run_req_s    = pick_req(1'b0, edge_s);

    // Next-state and pulse decode
    always_comb begin
        state_d     = state_q;
        req_d       = '0;
        abort_d     = 1'b0;
        power_act_s = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (long_press_s) begin
                    state_d     = ST_STANDBY;
                    power_act_s = 1'b1;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_STANDBY: begin
                if (pwr_edge_s) begin
                    state_d     = ST_OFF;
                    power_act_s = 1'b1;
                end else if (edge_s[KEY_MENU]) begin
                    state_d = ST_MENU;
                end else begin
                    state_d = ST_STANDBY;
                end
            end
            ST_MENU: begin
                if (pwr_edge_s) begin
                    state_d     = ST_OFF;
                    power_act_s = 1'b1;
                end else if (edge_s[KEY_MENU]) begin
                    state_d = ST_STANDBY;
                end else if (menu_req_s != '0) begin
                    req_d   = menu_req_s;
                    state_d = ST_RUN;
                end else if ((edge_s == '0) && (idle_q == IDLE_W'(MENU_TIMEOUT_CYCLES - 32'd1))) begin
                    state_d = ST_STANDBY;
                end else begin
                    state_d = ST_MENU;
                end
            end
            ST_RUN: begin
                if (long_press_s) begin
                    state_d     = ST_OFF;
                    abort_d     = 1'b1;
                    power_act_s = 1'b1;
                end else begin
                    req_d = run_req_s;
                    // Once busy was seen, its fall means the mode finished.
                    if (seen_q) begin
                        if (!panel.busy) begin
                            state_d = ST_STANDBY;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (panel.busy) begin
                        state_d = ST_RUN;
                    end else if (ack_q == ACK_W'(RUN_ACK_CYCLES - 32'd1)) begin
                        state_d = ST_MENU;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Counters, arming and status decode
    always_comb begin
        stay_menu_s = (state_q == ST_MENU) && (state_d == ST_MENU) && (edge_s == '0);
        stay_run_s  = (state_q == ST_RUN) && (state_d == ST_RUN);

        if (!level_s[KEY_POWER] || power_act_s) begin
            lp_d = '0;
        end else if (armed_q && (lp_q != {LP_W{1'b1}})) begin
            lp_d = lp_q + LP_W'(1);
        end else begin
            lp_d = lp_q;
        end

        if (power_act_s) begin
            armed_d = 1'b0;
        end else if (!level_s[KEY_POWER]) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        if (!stay_menu_s) begin
            idle_d = '0;
        end else if (idle_q != {IDLE_W{1'b1}}) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = idle_q;
        end

        if (!stay_run_s) begin
            ack_d  = '0;
            seen_d = 1'b0;
        end else if (ack_q != {ACK_W{1'b1}}) begin
            ack_d  = ack_q + ACK_W'(1);
            seen_d = seen_q | panel.busy;
        end else begin
            ack_d  = ack_q;
            seen_d = seen_q | panel.busy;
        end

        power_on_d = (state_d != ST_OFF);
        menu_d     = (state_d == ST_MENU);
    end

    // State, counter and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_OFF;
            armed_q    <= 1'b1;
            lp_q       <= '0;
            idle_q     <= '0;
            ack_q      <= '0;
            seen_q     <= 1'b0;
            req_q      <= '0;
            abort_q    <= 1'b0;
            power_on_q <= 1'b0;
            menu_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            lp_q       <= lp_d;
            idle_q     <= idle_d;
            ack_q      <= ack_d;
            seen_q     <= seen_d;
            req_q      <= req_d;
            abort_q    <= abort_d;
            power_on_q <= power_on_d;
            menu_q     <= menu_d;
        end
    end

    assign panel.power_on    = power_on_q;
    assign panel.menu_active = menu_q;
    assign panel.first_req   = req_q.first;
    assign panel.second_req  = req_q.second;
    assign panel.third_req   = req_q.third;
    assign panel.clean_req   = req_q.clean;
    assign panel.abort       = abort_q;
    assign panel.state_dbg   = state_q;
endmodule

// File: tb/tb_hood_menu_ctrl.sv
// Directed bench for hood_menu_ctrl with a cycle-level behavioural model of
// the panel rules, compared against the outputs on every falling clock edge.
module tb_hood_menu_ctrl;
    localparam int LP  = 20;
    localparam int MT  = 50;
    localparam int ACK = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    hood_menu_ctrl_if bus ();

    hood_menu_ctrl #(
        .LONG_PRESS_CYCLES   (LP),
        .MENU_TIMEOUT_CYCLES (MT),
        .RUN_ACK_CYCLES      (ACK)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .panel  (bus)
    );

    always #5 clk = ~clk;

    // keys: [0] power [1] menu [2] gear1 [3] gear2 [4] gear3 [5] clean
    wire [5:0] keys_s = {bus.clean_key, bus.gear3_key, bus.gear2_key,
                         bus.gear1_key, bus.menu_key, bus.power_key};
    wire [8:0] dut_v  = {bus.power_on, bus.menu_active, bus.first_req, bus.second_req,
                         bus.third_req, bus.clean_req, bus.abort, bus.state_dbg};

    typedef struct {
        int       st;        // 0 OFF, 1 STANDBY, 2 MENU, 3 RUN
        bit       armed;
        int       held;      // consecutive armed cycles with power held
        int       quiet;     // consecutive MENU cycles without any key edge
        int       run_age;   // cycles spent in RUN so far
        bit       ack_seen;
        bit [5:0] prev;
        bit       r1, r2, r3, rc, abort;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{st: 0, armed: 1'b1, held: 0, quiet: 0, run_age: 0, ack_seen: 1'b0,
              prev: 6'b111111, r1: 1'b0, r2: 1'b0, r3: 1'b0, rc: 1'b0, abort: 1'b0};
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t c, bit [5:0] keys, bit busy);
        mdl_t     n;
        bit [5:0] e;
        int       held_now;
        bit       act;
        bit       lp;
        n = c;
        e = keys & ~c.prev;
        n.prev = keys;
        {n.r1, n.r2, n.r3, n.rc, n.abort} = 5'b0;
        act = 1'b0;
        held_now = (keys[0] && c.armed) ? c.held + 1 : 0;
        lp = (held_now == LP);
        case (c.st)
            0: if (lp) begin n.st = 1; act = 1'b1; end
            1: if (e[0] && c.armed) begin n.st = 0; act = 1'b1; end
               else if (e[1]) n.st = 2;
            2: if (e[0] && c.armed) begin n.st = 0; act = 1'b1; end
               else if (e[1]) n.st = 1;
               else if (e[5]) begin n.rc = 1'b1; n.st = 3; end
               else if (e[2]) begin n.r1 = 1'b1; n.st = 3; end
               else if (e[3]) begin n.r2 = 1'b1; n.st = 3; end
               else if (e[4]) begin n.r3 = 1'b1; n.st = 3; end
               else if (e == 6'b0 && c.quiet + 1 == MT) n.st = 1;
            3: if (lp) begin n.st = 0; n.abort = 1'b1; act = 1'b1; end
               else begin
                   if (e[2]) n.r1 = 1'b1;
                   else if (e[3]) n.r2 = 1'b1;
                   else if (e[4]) n.r3 = 1'b1;
                   if (c.ack_seen) begin
                       if (!busy) n.st = 1;
                   end else if (busy) n.ack_seen = 1'b1;
                   else if (c.run_age + 1 == ACK) n.st = 2;
               end
            default: n.st = 0;
        endcase
        n.held    = act ? 0 : held_now;
        n.armed   = act ? 1'b0 : (!keys[0] ? 1'b1 : c.armed);
        n.quiet   = (c.st == 2 && n.st == 2 && e == 6'b0) ? c.quiet + 1 : 0;
        n.run_age = (c.st == 3 && n.st == 3) ? c.run_age + 1 : 0;
        if (!(c.st == 3 && n.st == 3)) n.ack_seen = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else        m <= mdl_step(m, keys_s, bus.busy);
    end

    always @(negedge clk) begin
        logic [8:0] exp_v;
        exp_v = {m.st != 0, m.st == 2, m.r1, m.r2, m.r3, m.rc, m.abort, 2'(m.st)};
        n_cmp++;
        if (dut_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t dut=%b model=%b", $time, dut_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        {bus.power_key, bus.menu_key, bus.gear1_key, bus.gear2_key,
         bus.gear3_key, bus.clean_key, bus.busy} = 7'b0;
        tick(3);
        chk("reset_outputs", dut_v, 9'd0);
        rst_n = 1'b1;
        tick(2);

        // Power-on by long press
        bus.power_key = 1'b1;
        tick(19);
        chk("lp19_still_off", {7'b0, bus.state_dbg}, 9'd0);
        tick(1);
        chk("lp20_standby", {bus.power_on, 6'b0, bus.state_dbg}, {1'b1, 6'b0, 2'd1});
        tick(30);
        chk("held_no_poweroff", {7'b0, bus.state_dbg}, 9'd1);
        bus.power_key = 1'b0;
        tick(2);

        // Menu then gear2 accepted by busy
        bus.menu_key = 1'b1;
        tick(1);
        chk("menu_open", {bus.menu_active, 6'b0, bus.state_dbg}, {1'b1, 6'b0, 2'd2});
        bus.menu_key = 1'b0;
        tick(1);
        bus.gear2_key = 1'b1;
        tick(1);
        chk("gear2_pulse", {6'b0, bus.second_req, bus.state_dbg}, {6'b0, 1'b1, 2'd3});
        bus.gear2_key = 1'b0;
        tick(1);
        chk("gear2_one_cycle", {8'b0, bus.second_req}, 9'd0);
        tick(1);
        bus.busy = 1'b1;
        tick(3);
        bus.busy = 1'b0;
        tick(1);
        chk("busy_fall_standby", {7'b0, bus.state_dbg}, 9'd1);

        // Rejected gear3, with a gear1 forwarded inside the ack window
        bus.menu_key = 1'b1;
        tick(1);
        bus.menu_key = 1'b0;
        tick(1);
        bus.gear3_key = 1'b1;
        tick(1);
        chk("gear3_pulse", {6'b0, bus.third_req, bus.state_dbg}, {6'b0, 1'b1, 2'd3});
        bus.gear3_key = 1'b0;
        tick(2);
        bus.gear1_key = 1'b1;
        tick(1);
        chk("run_gear1_fwd", {6'b0, bus.first_req, bus.state_dbg}, {6'b0, 1'b1, 2'd3});
        bus.gear1_key = 1'b0;
        tick(4);
        chk("ack_window_run", {7'b0, bus.state_dbg}, 9'd3);
        tick(1);
        chk("reject_to_menu", {7'b0, bus.state_dbg}, 9'd2);

        // Menu idle timeout
        tick(49);
        chk("idle49_menu", {7'b0, bus.state_dbg}, 9'd2);
        tick(1);
        chk("idle50_standby", {7'b0, bus.state_dbg}, 9'd1);

        // Menu edge beats clean edge
        bus.menu_key = 1'b1;
        tick(1);
        bus.menu_key = 1'b0;
        tick(1);
        {bus.menu_key, bus.clean_key} = 2'b11;
        tick(1);
        chk("menu_beats_clean", {6'b0, bus.clean_req, bus.state_dbg}, {6'b0, 1'b0, 2'd1});
        {bus.menu_key, bus.clean_key} = 2'b00;
        tick(1);

        // Forced off from RUN
        bus.menu_key = 1'b1;
        tick(1);
        bus.menu_key = 1'b0;
        tick(1);
        bus.clean_key = 1'b1;
        tick(1);
        chk("clean_pulse", {6'b0, bus.clean_req, bus.state_dbg}, {6'b0, 1'b1, 2'd3});
        bus.clean_key = 1'b0;
        bus.busy = 1'b1;
        bus.power_key = 1'b1;
        tick(19);
        chk("short_press_run", {bus.power_on, 5'b0, bus.abort, bus.state_dbg}, {1'b1, 5'b0, 1'b0, 2'd3});
        tick(1);
        chk("forced_off", {bus.power_on, 5'b0, bus.abort, bus.state_dbg}, {1'b0, 5'b0, 1'b1, 2'd0});
        bus.busy = 1'b0;
        bus.power_key = 1'b0;
        tick(1);
        chk("abort_one_cycle", {8'b0, bus.abort}, 9'd0);

        // Short press powers off from STANDBY
        bus.power_key = 1'b1;
        tick(20);
        bus.power_key = 1'b0;
        tick(1);
        bus.power_key = 1'b1;
        tick(1);
        chk("standby_power_edge", {bus.power_on, 6'b0, bus.state_dbg}, 9'd0);
        bus.power_key = 1'b0;
        tick(1);

        // Reset while in MENU, released with gear1 held
        bus.power_key = 1'b1;
        tick(20);
        bus.power_key = 1'b0;
        tick(1);
        bus.menu_key = 1'b1;
        tick(1);
        bus.menu_key = 1'b0;
        tick(1);
        chk("pre_reset_menu", {7'b0, bus.state_dbg}, 9'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_v, 9'd0);
        bus.gear1_key = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("held_gear1_no_req", dut_v, 9'd0);
        bus.gear1_key = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
